// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared register map, control/status bit positions and threshold helper
// for the PS/2 keyboard controller.
package ps2_kbd_ctrl_pkg;

  localparam logic [2:0] PS2C_DATA   = 3'd0;
  localparam logic [2:0] PS2C_STATUS = 3'd1;
  localparam logic [2:0] PS2C_CTRL   = 3'd2;
  localparam logic [2:0] PS2C_THRESH = 3'd3;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int STAT_NEMPTY  = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  // A programmed threshold of zero behaves like one.
  function automatic logic [7:0] thresh_eff(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Keycode FIFO: push/pop/flush, head valid the cycle after a push.
// A push while full is only accepted if a pop frees the slot in the same cycle.
module ps2_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_next,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t         rd_ptr, wr_ptr;
  logic         pop_eff, wr_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_eff = pop & ~empty & ~flush;
  assign wr_en   = push & ~flush & (~full | pop_eff);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (wr_en & ~pop_eff)
      count_next = count + CW'(1);
    else if (~wr_en & pop_eff)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en)   wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop_eff) rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Storage is deliberately left unreset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard MMIO controller: edge-detected keycodes queued in a FIFO,
// popped through a register window, with a threshold-based level interrupt.
module ps2_kbd_ctrl
  import ps2_kbd_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int KW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    a,
  input  logic [31:0]   d,
  input  logic          we,
  input  logic          re,
  output logic [31:0]   spo,
  output logic          irq,
  input  logic [KW-1:0] key_code,
  input  logic          key_new
);

  logic                key_new_q;
  logic                ovf, irq_en;
  logic [7:0]          thresh;
  logic                push, pop, flush, ovf_clr, ovf_set;
  logic [KW-1:0]       head;
  logic [DEPTH_LOG2:0] count, count_next;
  logic                full, empty;
  logic                unused_d;

  assign unused_d = &{1'b0, d[31:8]};

  assign push    = key_new & ~key_new_q;
  assign pop     = re & (a == PS2C_DATA);
  assign flush   = we & (a == PS2C_CTRL) & d[CTRL_FLUSH];
  assign ovf_clr = we & (a == PS2C_CTRL) & d[CTRL_OVF_CLR];
  // Dropped code: FIFO full, no pop freeing a slot, and no flush swallowing it.
  assign ovf_set = push & full & ~pop & ~flush;

  ps2_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(KW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .din        (key_code),
    .head       (head),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_new_q <= 1'b0;
      ovf       <= 1'b0;
      irq_en    <= 1'b0;
      thresh    <= 8'd1;
      irq       <= 1'b0;
    end else begin
      key_new_q <= key_new;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (we && a == PS2C_CTRL)   irq_en <= d[CTRL_IRQ_EN];
      if (we && a == PS2C_THRESH) thresh <= d[7:0];
      irq <= irq_en & (8'(count_next) >= thresh_eff(thresh));
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      PS2C_DATA:   spo = 32'(head);
      PS2C_STATUS: begin
        spo[STAT_NEMPTY]               = ~empty;
        spo[STAT_FULL]                 = full;
        spo[STAT_OVF]                  = ovf;
        spo[STAT_CNT_LSB +: 8]         = 8'(count);
      end
      PS2C_CTRL:   spo[CTRL_IRQ_EN] = irq_en;
      PS2C_THRESH: spo[7:0] = thresh;
      default:     spo = '0;
    endcase
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl with a 4-entry FIFO.
module tb_ps2_kbd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] spo;
  logic        irq;
  logic [31:0] key_code = '0;
  logic        key_new = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.DEPTH_LOG2(2), .KW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .d        (d),
    .we       (we),
    .re       (re),
    .spo      (spo),
    .irq      (irq),
    .key_code (key_code),
    .key_new  (key_new)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_code(input logic [31:0] c);
    @(negedge clk);
    key_code = c;
    key_new  = 1'b1;
    @(negedge clk);
    key_new  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, input logic pop, output logic [31:0] val);
    @(negedge clk);
    a  = addr;
    re = pop;
    #1 val = spo;
    @(posedge clk);
    #1 re = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    d  = data;
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd(3'd1, 1'b0, v); chk("rst_status", v, 32'h0);
    rd(3'd2, 1'b0, v); chk("rst_ctrl", v, 32'h0);
    rd(3'd3, 1'b0, v); chk("rst_thresh", v, 32'h1);
    rd(3'd0, 1'b1, v); chk("rst_data_empty", v, 32'h0);
    rd(3'd5, 1'b0, v); chk("unmapped_rd", v, 32'h0);

    // Make/break sequence
    push_code(32'h1C); push_code(32'hF0); push_code(32'h1C);
    rd(3'd1, 1'b0, v); chk("seq_status", v, 32'h301);
    rd(3'd0, 1'b1, v); chk("seq_pop0", v, 32'h1C);
    rd(3'd0, 1'b1, v); chk("seq_pop1", v, 32'hF0);
    rd(3'd0, 1'b1, v); chk("seq_pop2", v, 32'h1C);
    rd(3'd1, 1'b0, v); chk("seq_status_end", v, 32'h0);

    // Overflow
    for (int i = 1; i <= 5; i++) push_code(32'(i));
    rd(3'd1, 1'b0, v); chk("ovf_status", v, 32'h407);
    for (int i = 1; i <= 4; i++) begin
      rd(3'd0, 1'b1, v); chk("ovf_pop", v, 32'(i));
    end
    rd(3'd1, 1'b0, v); chk("ovf_sticky", v, 32'h4);
    wr(3'd2, 32'h4);
    rd(3'd1, 1'b0, v); chk("ovf_cleared", v, 32'h0);

    // Held key_new pushes once
    @(negedge clk);
    key_code = 32'hAA;
    key_new  = 1'b1;
    repeat (10) @(negedge clk);
    key_new = 1'b0;
    rd(3'd1, 1'b0, v); chk("held_status", v, 32'h101);
    rd(3'd0, 1'b1, v); chk("held_data", v, 32'hAA);
    rd(3'd1, 1'b0, v); chk("held_empty", v, 32'h0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push_code(32'h10 + 32'(i));
    @(negedge clk);
    a = 3'd0; re = 1'b1; key_code = 32'h14; key_new = 1'b1;
    #1 chk("pp_head", spo, 32'h10);
    @(posedge clk);
    #1 re = 1'b0;
    @(negedge clk);
    key_new = 1'b0;
    rd(3'd1, 1'b0, v); chk("pp_status", v, 32'h403);
    for (int i = 1; i <= 4; i++) begin
      rd(3'd0, 1'b1, v); chk("pp_pop", v, 32'h10 + 32'(i));
    end

    // Interrupt threshold
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h2);
    push_code(32'h21);
    chk("irq_one", {31'b0, irq}, 32'h0);
    push_code(32'h22);
    chk("irq_two", {31'b0, irq}, 32'h1);
    rd(3'd0, 1'b1, v);
    @(negedge clk);
    chk("irq_drop", {31'b0, irq}, 32'h0);
    rd(3'd0, 1'b1, v); chk("irq_pop2", v, 32'h22);
    wr(3'd3, 32'h0);
    push_code(32'h23);
    chk("irq_thresh0", {31'b0, irq}, 32'h1);
    rd(3'd3, 1'b0, v); chk("thresh0_rd", v, 32'h0);
    rd(3'd0, 1'b1, v);
    @(negedge clk);
    chk("irq_thresh0_drop", {31'b0, irq}, 32'h0);
    wr(3'd3, 32'h5);
    for (int i = 0; i < 4; i++) push_code(32'h30 + 32'(i));
    chk("irq_above_depth", {31'b0, irq}, 32'h0);

    // Flush coinciding with a push (ovf set beforehand)
    push_code(32'h40);
    rd(3'd1, 1'b0, v); chk("fl_pre", v, 32'h407);
    @(negedge clk);
    a = 3'd2; d = 32'h3; we = 1'b1; key_code = 32'h77; key_new = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    @(negedge clk);
    key_new = 1'b0;
    rd(3'd1, 1'b0, v); chk("fl_status", v, 32'h4);
    rd(3'd0, 1'b0, v); chk("fl_data", v, 32'h0);
    wr(3'd2, 32'h5);
    rd(3'd1, 1'b0, v); chk("fl_ovf_clr", v, 32'h0);

    // Asynchronous reset mid-operation
    wr(3'd3, 32'h2);
    push_code(32'h51); push_code(32'h52); push_code(32'h53);
    chk("ar_irq_pre", {31'b0, irq}, 32'h1);
    @(negedge clk);
    a = 3'd1;
    #2 rst = 1'b0;
    #1 chk("ar_irq", {31'b0, irq}, 32'h0);
    chk("ar_status", spo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd(3'd2, 1'b0, v); chk("ar_ctrl", v, 32'h0);
    rd(3'd3, 1'b0, v); chk("ar_thresh", v, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
